// File: rtl/adder_tree_pkg.sv
// Shared types and sizes for the 8-operand adder tree and its operand feeder.
package adder_tree_pkg;
    localparam int ADDER_WIDTH = 19;
    localparam int TREE_LANES  = 8;
    localparam int CNT_W       = $clog2(TREE_LANES) + 1;

    typedef logic [ADDER_WIDTH-1:0] operand_t;
    typedef operand_t frame_t [TREE_LANES];
endpackage

// File: rtl/feeder_bank.sv
// One frame buffer: LANES operand registers plus its full flag and operand count.
module feeder_bank
    import adder_tree_pkg::*;
#(
    parameter  int WIDTH = ADDER_WIDTH,
    parameter  int LANES = TREE_LANES,
    parameter  int CNT_W = $clog2(LANES) + 1,
    localparam int IDX_W = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_en,
    input  logic                   i_start,
    input  logic [IDX_W-1:0]       i_idx,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_set_full,
    input  logic [CNT_W-1:0]       i_count,
    input  logic                   i_clr_full,
    output logic                   o_full,
    output logic [CNT_W-1:0]       o_count,
    output logic [LANES*WIDTH-1:0] o_data
);
    logic [LANES-1:0][WIDTH-1:0] r_lanes;
    logic                        r_full;
    logic [CNT_W-1:0]            r_count;

    // Starting a frame wipes every lane so a short frame is zero-padded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_start) r_lanes[i] <= '0;
            end
            r_lanes[i_idx] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_count <= '0;
        end else if (i_set_full) begin
            r_full  <= 1'b1;
            r_count <= i_count;
        end else if (i_clr_full) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_count = r_count;
    assign o_data  = r_lanes;
endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a serial operand stream into LANES-wide frames through two ping-pong banks.
module adder_tree_feeder
    import adder_tree_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int LANES = TREE_LANES,
    parameter int CNT_W = $clog2(LANES) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]       m_count
);
    localparam int IDX_W = $clog2(LANES);

    logic                   r_wb;
    logic                   r_rb;
    logic [IDX_W-1:0]       r_idx;

    logic [1:0]             w_full;
    logic [CNT_W-1:0]       w_bank_count [2];
    logic [LANES*WIDTH-1:0] w_bank_data  [2];
    logic                   w_accept;
    logic                   w_close;
    logic                   w_consume;
    logic [CNT_W-1:0]       w_close_count;

    assign w_accept      = s_valid && s_ready;
    assign w_close       = w_accept && (s_last || (r_idx == IDX_W'(LANES - 1)));
    assign w_consume     = m_valid && m_ready;
    assign w_close_count = CNT_W'(r_idx) + CNT_W'(1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        feeder_bank #(
            .WIDTH (WIDTH),
            .LANES (LANES),
            .CNT_W (CNT_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_en    (w_accept && (r_wb == 1'(b))),
            .i_start    (r_idx == '0),
            .i_idx      (r_idx),
            .i_data     (s_data),
            .i_set_full (w_close && (r_wb == 1'(b))),
            .i_count    (w_close_count),
            .i_clr_full (w_consume && (r_rb == 1'(b))),
            .o_full     (w_full[b]),
            .o_count    (w_bank_count[b]),
            .o_data     (w_bank_data[b])
        );
    end

    // A close and a consume always target different banks, so both pointers move freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb  <= 1'b0;
            r_rb  <= 1'b0;
            r_idx <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= w_close ? '0 : r_idx + IDX_W'(1);
            end
            if (w_close)   r_wb <= ~r_wb;
            if (w_consume) r_rb <= ~r_rb;
        end
    end

    assign s_ready = !w_full[r_wb];
    assign m_valid = w_full[r_rb];
    assign m_data  = w_bank_data[r_rb];
    assign m_count = w_bank_count[r_rb];
endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder: vector table, directed corner sequences, random traffic vs a frame-queue model.
module tb_adder_tree_feeder;
    import adder_tree_pkg::*;

    localparam int W  = ADDER_WIDTH;
    localparam int L  = TREE_LANES;
    localparam int CW = CNT_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [W-1:0]      s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [L*W-1:0]    m_data;
    logic [CW-1:0]     m_count;

    adder_tree_feeder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] data;
        int             count;
    } frm_t;

    typedef struct {
        logic     v;
        operand_t d;
        logic     l;
        logic     mr;
        logic     e_sr;
        logic     e_mv;
        int       e_cnt;
        int       e_sum;
    } vec_t;

    frm_t     pend[$];
    operand_t part[$];
    int       errors = 0;
    int       checks = 0;

    task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane_sum(input logic [L*W-1:0] d);
        frame_t f;
        int     s = 0;
        for (int i = 0; i < L; i++) f[i] = d[i*W +: W];
        for (int i = 0; i < L; i++) s += int'(f[i]);
        return s;
    endfunction

    task automatic model_check();
        chk("s_ready", L*W'(s_ready), L*W'(pend.size() < 2));
        chk("m_valid", L*W'(m_valid), L*W'(pend.size() > 0));
        if (pend.size() > 0) begin
            chk("m_data", m_data, pend[0].data);
            chk("m_count", L*W'(m_count), L*W'(pend[0].count));
        end
    endtask

    // Checks outputs against the model, applies one cycle of inputs, advances the model.
    task automatic step(input logic v, input operand_t d, input logic l, input logic mr);
        logic           acc;
        logic           cons;
        logic [L*W-1:0] f;
        model_check();
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        acc  = v && (pend.size() < 2);
        cons = mr && (pend.size() > 0);
        @(posedge clk);
        if (cons) void'(pend.pop_front());
        if (acc) begin
            part.push_back(d);
            if (l || part.size() == L) begin
                f = '0;
                for (int i = 0; i < part.size(); i++) f[i*W +: W] = part[i];
                pend.push_back('{data: f, count: part.size()});
                part.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    vec_t vecs[15];
    int   frames;

    initial begin
        for (int i = 0; i < 7; i++) vecs[i] = '{1'b1, operand_t'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[7]  = '{1'b1, 19'd8, 1'b0, 1'b1, 1'b1, 1'b1, 8, 36};
        vecs[8]  = '{1'b0, 19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[9]  = '{1'b1, 19'd5, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[10] = '{1'b1, 19'd6, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[11] = '{1'b1, 19'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 18};
        vecs[12] = '{1'b0, 19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[13] = '{1'b1, 19'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9};
        vecs[14] = '{1'b0, 19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset s_ready", L*W'(s_ready), L*W'(1));
        chk("reset m_valid", L*W'(m_valid), '0);
        chk("reset m_data", m_data, '0);
        chk("reset m_count", L*W'(m_count), '0);

        // Full frame, short frame, then a 1-operand frame reusing bank 0.
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mr);
            chk($sformatf("vec%0d s_ready", i), L*W'(s_ready), L*W'(vecs[i].e_sr));
            chk($sformatf("vec%0d m_valid", i), L*W'(m_valid), L*W'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                chk($sformatf("vec%0d m_count", i), L*W'(m_count), L*W'(vecs[i].e_cnt));
                chk($sformatf("vec%0d tree sum", i), L*W'(lane_sum(m_data)), L*W'(vecs[i].e_sum));
            end
        end

        // Backpressure: two frames pend, the 17th operand is held off.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, operand_t'(i), 1'b0, 1'b0);
            if (i == 8) chk("bp frame1 sum", L*W'(lane_sum(m_data)), L*W'(36));
        end
        chk("bp s_ready low", L*W'(s_ready), '0);
        step(1'b1, 19'd17, 1'b0, 1'b0);
        chk("bp held s_ready", L*W'(s_ready), '0);
        step(1'b1, 19'd17, 1'b0, 1'b1);
        chk("bp s_ready after consume", L*W'(s_ready), L*W'(1));
        chk("bp frame2 valid", L*W'(m_valid), L*W'(1));
        chk("bp frame2 sum", L*W'(lane_sum(m_data)), L*W'(100));
        step(1'b1, 19'd17, 1'b0, 1'b1);
        step(1'b1, 19'd18, 1'b1, 1'b0);
        chk("bp tail count", L*W'(m_count), L*W'(2));
        drain();

        // Close of one bank collides with consume of the other.
        for (int i = 0; i < 8; i++) step(1'b1, operand_t'(101 + i), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, operand_t'(201 + i), 1'b0, 1'b0);
        step(1'b1, 19'd208, 1'b0, 1'b1);
        chk("collide m_valid", L*W'(m_valid), L*W'(1));
        chk("collide m_count", L*W'(m_count), L*W'(8));
        chk("collide sum", L*W'(lane_sum(m_data)), L*W'(1636));
        drain();

        // Streaming: 64 back-to-back operands with the consumer always ready.
        frames = 0;
        for (int i = 0; i < 64; i++) begin
            if (m_valid) frames++;
            chk("stream s_ready", L*W'(s_ready), L*W'(1));
            step(1'b1, operand_t'($urandom_range(0, (1 << W) - 1)), 1'b0, 1'b1);
        end
        if (m_valid) frames++;
        step(1'b0, '0, 1'b0, 1'b1);
        chk("stream frames", L*W'(frames), L*W'(8));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), operand_t'($urandom_range(0, (1 << W) - 1)),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end
        drain();
        for (int i = 0; i < 8; i++) step(1'b1, operand_t'(i + 1), 1'b0, 1'b1);
        drain();

        // Reset mid-frame with one frame pending.
        for (int i = 0; i < 11; i++) step(1'b1, operand_t'(500 + i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst m_valid", L*W'(m_valid), '0);
        chk("midrst s_ready", L*W'(s_ready), L*W'(1));
        chk("midrst m_count", L*W'(m_count), '0);
        chk("midrst m_data", m_data, '0);
        pend.delete();
        part.delete();
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) step(1'b1, operand_t'(i), 1'b0, 1'b0);
        chk("postrst m_valid", L*W'(m_valid), L*W'(1));
        chk("postrst m_count", L*W'(m_count), L*W'(8));
        chk("postrst sum", L*W'(lane_sum(m_data)), L*W'(36));
        drain();
        model_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Producer side of the 8-operand adder tree: accepts a serial stream of 19-bit operands over a valid/ready handshake and packs them into 8-lane frames.
- Each frame is presented on a parallel bus for the tree's isum inputs, together with a valid/ready handshake.
- Ping-pong double buffering lets one frame fill while the previous one waits for the consumer, so the stream sustains 1 operand/cycle.
- Short frames (closed by s_last) are zero-padded so the downstream sum stays correct.

Parameters:
- WIDTH, 19, operand width in bits (matches tree leaf width)
- LANES, 8, operands per frame (power of 2, >= 2)
- CNT_W, $clog2(LANES)+1, width of the lane-count field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input operand valid
- s_ready  out  1  feeder can accept an operand this cycle
- s_data  in  WIDTH  operand
- s_last  in  1  operand closes the current frame early; qualified by s_valid & s_ready
- m_valid  out  1  frame available
- m_ready  in  1  consumer accepts the frame
- m_data  out  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]; lane 0 is the first operand received
- m_count  out  CNT_W  number of real operands in the frame (1..LANES)

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: s_ready=1, m_valid=0, m_data=0, m_count=0. Both banks are empty, write bank=0, read bank=0, and the fill index is 0.
- Storage:
  - Two banks, each LANES x WIDTH, with a per-bank full flag and a per-bank count.
  - Writes go to the write bank (wb); the output always shows the read bank (rb).
- Accept:
  - An operand is accepted on s_valid & s_ready.
  - s_ready = !full[wb]. It is registered-state-derived with no combinational path from m_ready.
- Fill rules:
  - Each accept writes lane[idx] of wb and increments idx.
  - The frame closes when idx reaches LANES-1 on the accept, or when s_last=1 on the accept.
  - On close: full[wb]<=1, count[wb]<=idx+1, idx<=0, wb toggles.
- Zero padding: when a bank starts a new frame (idx==0 accept), all lanes of that bank are cleared in the same cycle, with lane 0 taking s_data. Unwritten lanes therefore read 0.
- Output:
  - m_valid = full[rb]; m_data = bank[rb]; m_count = count[rb].
  - All three are stable while m_valid=1 and m_ready=0.
- Consume: on m_valid & m_ready, full[rb]<=0 and rb toggles.
- Latency: the frame-closing accept happens at edge N; m_valid=1 is visible after edge N, i.e. the same cycle the consumer can sample it. There is no extra pipeline stage.
- Throughput: continuous s_valid with m_ready=1 gives s_ready held at 1 and one frame every LANES cycles.
- Simultaneous events:
  - A close into bank X and a consume of bank Y (X≠Y) in the same cycle are both honoured.
  - A consume that frees the bank wb points at raises s_ready on the next cycle, not the same cycle.
- Both banks full: s_ready=0 until a consume.
- s_last on lane LANES-1 behaves the same as a normal full close; count=LANES.
- s_valid without s_ready (stall): no state change; s_data and s_last are ignored.
- Reset mid-frame: the partial frame and any pending frames are discarded. Outputs return to their reset values asynchronously.
- idx wraps only via the close rule and never exceeds LANES-1.

Decomposition:
- Shared package adder_tree_pkg:
  - ADDER_WIDTH=19, TREE_LANES=8, CNT_W.
  - typedef operand_t logic[ADDER_WIDTH-1:0].
  - typedef frame_t operand_t[TREE_LANES].
- One sub-module, feeder_bank:
  - One LANES x WIDTH register bank with a synchronous clear-on-start, a lane write enable and index, full/count flags, and set/clear inputs.
  - The top instantiates it twice and holds the wb/rb/idx control.

Test Plan:
- Single full frame: after reset, send 1..8 on consecutive cycles with m_ready=1. Expect m_valid for exactly 1 cycle, m_data lanes 0..7 = 1..8, m_count=8, and a downstream tree sum of 36.
- Short frame: send 5, 6, 7 with s_last on 7. Expect lanes = 5,6,7,0,0,0,0,0, m_count=3, and the next frame starting at lane 0.
- Backpressure:
  - Hold m_ready=0 and stream 16 operands: s_ready drops after the 16th accept, and the 17th is held off.
  - Then raise m_ready: frames appear in order (1..8, then 9..16), and s_ready returns 1 cycle after the first consume.
- Streaming: 64 operands back-to-back with m_ready=1. Expect s_ready constantly 1, 8 frames, and no lost or duplicated operands (scoreboard).
- Close/consume collision: with bank 0 pending and m_ready rising on the same cycle bank 1's 8th operand is accepted, expect bank 0 consumed and bank 1 presented on the next cycle with its data intact.
- Reset mid-frame: after 3 operands accepted and one frame pending, assert rst_n=0 between clock edges. Expect m_valid=0 and s_ready=1 immediately; the next 8 operands form a clean frame with no stale lanes.
